// File: rtl/io_bridge_pkg.sv
// Shared page constants, read-select encoding and page decode for io_bridge.
package io_bridge_pkg;

  localparam logic [3:0] PAGE_MEM = 4'h0;
  localparam logic [3:0] PAGE_IN  = 4'hF;

  typedef enum logic [2:0] {
    SEL_MEM,
    SEL_OUT,
    SEL_IN_LIVE,
    SEL_IN_CAP,
    SEL_NONE
  } rd_sel_e;

  function automatic rd_sel_e decode_sel(input logic [3:0] page, input logic a0,
                                         input logic [3:0] n_out);
    if (page == PAGE_MEM) return SEL_MEM;
    if (page == PAGE_IN) return a0 ? SEL_IN_CAP : SEL_IN_LIVE;
    if (page <= n_out) return SEL_OUT;
    return SEL_NONE;
  endfunction

endpackage

// File: rtl/io_edge_capture.sv
// Two-flop input synchroniser with sticky rising-edge capture and write-one-to-clear mask.
module io_edge_capture #(
  parameter int unsigned IN_W = 16
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [IN_W-1:0] in_i,
  input  logic            clr_en_i,
  input  logic [IN_W-1:0] clr_mask_i,
  output logic [IN_W-1:0] sync_o,
  output logic [IN_W-1:0] cap_o
);

  logic [IN_W-1:0] meta_q, sync_q, prev_q, cap_q, cap_d;

  // Set is OR-ed in after the clear so a same-cycle edge survives the clear.
  always_comb begin
    cap_d = cap_q;
    if (clr_en_i) cap_d = cap_d & ~clr_mask_i;
    cap_d = cap_d | (sync_q & ~prev_q);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= '0;
      sync_q <= '0;
      prev_q <= '0;
      cap_q  <= '0;
    end else begin
      meta_q <= in_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
      cap_q  <= cap_d;
    end
  end

  assign sync_o = sync_q;
  assign cap_o  = cap_q;

endmodule

// File: rtl/io_bridge.sv
// Processor IO bridge: page 0 memory, pages 1..N_OUT output registers, page 0xF inputs.
// Optional edge-capture register enabled by defining IO_BRIDGE_EDGE_CAPTURE_EN.
module io_bridge
  import io_bridge_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned MEM_AW = 7,
  parameter int unsigned N_OUT  = 2,
  parameter int unsigned IN_W   = 16
) (
  input  logic                    Clock,
  input  logic                    Reset,
  input  logic [ADDR_W-1:0]       ADDR,
  input  logic [DATA_W-1:0]       DOUT,
  input  logic                    W,
  input  logic [DATA_W-1:0]       MEM_Q,
  input  logic [IN_W-1:0]         IN_PORT,
  output logic [MEM_AW-1:0]       mem_addr,
  output logic                    mem_wren,
  output logic [N_OUT*DATA_W-1:0] OUT_Q,
  output logic [DATA_W-1:0]       DIN
);

  localparam logic [3:0] NOutPages = 4'(N_OUT);

  logic [3:0] page;
  rd_sel_e    sel_d, sel_q;
  logic [3:0] out_idx_q;

  logic [N_OUT-1:0][DATA_W-1:0] out_q;
  logic [DATA_W-1:0]            out_rd, live_ext, cap_ext;
  logic [IN_W-1:0]              in_sync, in_cap;

  assign page     = ADDR[ADDR_W-1 -: 4];
  assign mem_addr = ADDR[MEM_AW-1:0];
  assign mem_wren = W & (page == PAGE_MEM);
  assign sel_d    = decode_sel(page, ADDR[0], NOutPages);
  assign OUT_Q    = out_q;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      out_q     <= '0;
      sel_q     <= SEL_MEM;
      out_idx_q <= '0;
    end else begin
      for (int k = 0; k < int'(N_OUT); k++) begin
        if (W && page == 4'(k + 1)) out_q[k] <= DOUT;
      end
      sel_q     <= sel_d;
      out_idx_q <= page - 4'd1;
    end
  end

`ifdef IO_BRIDGE_EDGE_CAPTURE_EN
  io_edge_capture #(
    .IN_W(IN_W)
  ) u_edge_capture (
    .clk_i     (Clock),
    .rst_i     (Reset),
    .in_i      (IN_PORT),
    .clr_en_i  (W && page == PAGE_IN && ADDR[0]),
    .clr_mask_i(DOUT[IN_W-1:0]),
    .sync_o    (in_sync),
    .cap_o     (in_cap)
  );
`else
  logic [IN_W-1:0] meta_q, sync_q;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= IN_PORT;
      sync_q <= meta_q;
    end
  end

  assign in_sync = sync_q;
  assign in_cap  = '0;
`endif

  // Output registers are read live so a write in the address cycle is visible.
  always_comb begin
    out_rd = '0;
    for (int k = 0; k < int'(N_OUT); k++) begin
      if (out_idx_q == 4'(k)) out_rd = out_q[k];
    end
    live_ext = '0;
    live_ext[IN_W-1:0] = in_sync;
    cap_ext = '0;
    cap_ext[IN_W-1:0] = in_cap;
  end

  always_comb begin
    DIN = '0;
    case (sel_q)
      SEL_MEM:     DIN = MEM_Q;
      SEL_OUT:     DIN = out_rd;
      SEL_IN_LIVE: DIN = live_ext;
      SEL_IN_CAP:  DIN = cap_ext;
      default:     DIN = '0;
    endcase
  end

endmodule

// File: tb/tb_io_bridge.sv
// Directed bench for io_bridge (default parameters) with a read-data scoreboard.
module tb_io_bridge;

  logic        Clock = 1'b0;
  logic        Reset;
  logic [15:0] ADDR, DOUT, MEM_Q, IN_PORT;
  logic        W;
  logic [6:0]  mem_addr;
  logic        mem_wren;
  logic [31:0] OUT_Q;
  logic [15:0] DIN;

  int n_checks = 0;
  int n_errors = 0;

  string       sb_tag[$];
  logic [15:0] sb_exp[$];
  logic [31:0] exp_out;
  logic [15:0] exp_cap;

  io_bridge dut (
    .Clock   (Clock),
    .Reset   (Reset),
    .ADDR    (ADDR),
    .DOUT    (DOUT),
    .W       (W),
    .MEM_Q   (MEM_Q),
    .IN_PORT (IN_PORT),
    .mem_addr(mem_addr),
    .mem_wren(mem_wren),
    .OUT_Q   (OUT_Q),
    .DIN     (DIN)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  // Present a read for one cycle; the expected DIN is queued for the following cycle.
  task automatic rd(input logic [15:0] addr, input logic [15:0] exp, input string tag);
    W = 1'b0;
    ADDR = addr;
    sb_tag.push_back(tag);
    sb_exp.push_back(exp);
    tick();
    if (sb_exp.size() == 0) begin
      check("sb_empty", 32'd1, 32'd0);
    end else begin
      check(sb_tag.pop_front(), {16'h0, DIN}, {16'h0, sb_exp.pop_front()});
    end
  endtask

  task automatic wr(input logic [15:0] addr, input logic [15:0] data);
    W = 1'b1;
    ADDR = addr;
    DOUT = data;
    #1;
    check("wr_mem_wren", {31'h0, mem_wren}, {31'h0, addr[15:12] == 4'h0});
    tick();
    W = 1'b0;
  endtask

  initial begin
    Reset = 1'b1; W = 1'b1; ADDR = 16'h1000; DOUT = 16'hAAAA;
    MEM_Q = 16'h5A5A; IN_PORT = 16'h0;
    exp_out = 32'h0;
    exp_cap = 16'h0;
    #1;
    check("rst_mem_wren", {31'h0, mem_wren}, 32'h0);
    tick();
    tick();
    check("rst_out_q", OUT_Q, 32'h0);
    check("rst_din_mem", {16'h0, DIN}, 32'h5A5A);
    Reset = 1'b0; W = 1'b0;
    MEM_Q = 16'hDEAD;
    tick();

    wr(16'h1000, 16'hBEEF); exp_out[15:0] = 16'hBEEF;
    check("out0_write", OUT_Q, exp_out);
    wr(16'h2000, 16'hCAFE); exp_out[31:16] = 16'hCAFE;
    check("out1_write", OUT_Q, exp_out);

    W = 1'b1; ADDR = 16'h0005; DOUT = 16'h4242;
    #1;
    check("mem_wren_pg0", {31'h0, mem_wren}, 32'h1);
    check("mem_addr_5", {25'h0, mem_addr}, 32'h5);
    ADDR = 16'h0FFF;
    #1;
    check("mem_addr_trunc", {25'h0, mem_addr}, 32'h7F);
    tick();
    W = 1'b0;
    check("mem_wr_no_out", OUT_Q, exp_out);

    MEM_Q = 16'h1234;
    rd(16'h0005, 16'h1234, "rd_mem");
    MEM_Q = 16'hDEAD;

    wr(16'h3000, 16'hFFFF);
    check("unmapped_wr", OUT_Q, exp_out);
    rd(16'h3000, 16'h0000, "rd_unmapped3");
    rd(16'hE000, 16'h0000, "rd_unmappedE");
    rd(16'h1000, 16'hBEEF, "rd_out0");
    rd(16'h2000, 16'hCAFE, "rd_out1");

    // Write and read in the same cycle: new value visible one cycle later.
    W = 1'b1; ADDR = 16'h1000; DOUT = 16'h1111; exp_out[15:0] = 16'h1111;
    sb_tag.push_back("rd_same_cycle_wr");
    sb_exp.push_back(16'h1111);
    tick();
    W = 1'b0;
    check(sb_tag.pop_front(), {16'h0, DIN}, {16'h0, sb_exp.pop_front()});

    IN_PORT = 16'h0001;
    rd(16'hF000, 16'h0000, "rd_live_early");
    tick();
    tick();
    rd(16'hF000, 16'h0001, "rd_live_sync");
`ifdef IO_BRIDGE_EDGE_CAPTURE_EN
    exp_cap = 16'h0001;
`endif
    rd(16'hF001, exp_cap, "rd_cap_set");

    wr(16'hF000, 16'hFFFF);
    check("live_wr_ignored", OUT_Q, exp_out);
    rd(16'hF000, 16'h0001, "rd_live_after_wr");

    wr(16'hF001, 16'h0001); exp_cap = 16'h0;
    rd(16'hF001, exp_cap, "rd_cap_cleared");

    // Re-arm bit 0, then clear it in the very cycle a fresh rising edge lands.
    IN_PORT = 16'h0; repeat (4) tick();
    IN_PORT = 16'h0001; repeat (4) tick();
    IN_PORT = 16'h0; repeat (4) tick();
    IN_PORT = 16'h0001;
    tick();
    tick();
    wr(16'hF001, 16'h0001);
`ifdef IO_BRIDGE_EDGE_CAPTURE_EN
    exp_cap = 16'h0001;
`endif
    rd(16'hF001, exp_cap, "rd_cap_set_wins");
    check("cap_clr_no_out", OUT_Q, exp_out);

    Reset = 1'b1; W = 1'b1; ADDR = 16'h2000; DOUT = 16'h7777;
    tick();
    check("midrst_out_q", OUT_Q, 32'h0);
    MEM_Q = 16'h9999;
    #1;
    check("midrst_din_mem", {16'h0, DIN}, 32'h9999);
    Reset = 1'b0; W = 1'b0;
    tick();
    rd(16'hF001, 16'h0000, "rd_cap_after_rst");
    check("sb_drained", sb_exp.size(), 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
